// File: rtl/glm_load_dram.sv
// glm_load_dram: issues CCI-P c0 line reads for a contiguous run and writes responses into BRAM channel 0 or 1.
// Define GLM_LOAD_ERR_EN to build the sticky load_error response checks.

package glm_ccip_pkg;
   typedef logic [41:0]  t_ccip_clAddr;
   typedef logic [15:0]  t_ccip_mdata;
   typedef logic [511:0] t_ccip_clData;

   typedef enum logic [1:0] {eVC_VA = 2'b00, eVC_VL0 = 2'b01, eVC_VH0 = 2'b10, eVC_VH1 = 2'b11} t_ccip_vc;
   typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
   typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
   typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic [1:0]   rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c0_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      t_ccip_vc     vc_used;
      logic         rsvd1;
      logic         hit_miss;
      logic [1:0]   rsvd0;
      logic [1:0]   cl_num;
      t_ccip_c0_rsp resp_type;
      t_ccip_mdata  mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      t_ccip_clData       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;
endpackage

module glm_load_dram
   import glm_ccip_pkg::*;
#(
   parameter int BRAM_AW         = 10,
   parameter int MAX_OUTSTANDING = 64,
   parameter int NUM_REGS        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_start,
   output logic                op_done,
   input  logic [31:0]         regs [NUM_REGS],
   input  t_ccip_clAddr        in_addr,
   input  t_ccip_clAddr        out_addr,
   input  logic                c0TxAlmFull,
   input  t_if_ccip_c0_Rx      cp2af_sRx_c0,
   output t_if_ccip_c0_Tx      af2cp_sTx_c0,
   output logic                mem0_we,
   output logic                mem1_we,
   output logic [BRAM_AW-1:0]  mem0_waddr,
   output logic [BRAM_AW-1:0]  mem1_waddr,
   output logic [511:0]        mem0_wdata,
   output logic [511:0]        mem1_wdata,
   output logic                load_error
);

   localparam int            OW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

   state_t             state_q, state_d;
   t_ccip_clAddr       base_q, base_d, sel_base;
   logic [15:0]        len_q, len_d, sent_q, sent_d, rcvd_q, rcvd_d;
   logic [3:0]         chan_q, chan_d;
   logic [BRAM_AW-1:0] bbase_q, bbase_d, waddr_q, waddr_d;
   logic [OW-1:0]      outst_q, outst_d;
   t_ccip_clData       wdata_q, wdata_d;
   t_if_ccip_c0_Tx     tx_q, tx_d;
   logic               we0_q, we0_d, we1_q, we1_d, done_q, done_d;
   logic               rsp_rd, rsp_bad, issue, accept;
   logic               unused_ok;

   assign rsp_rd   = cp2af_sRx_c0.rspValid && (cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE);
   assign sel_base = regs[3][31] ? in_addr : out_addr;
   assign issue    = (state_q == S_READ) && (sent_q < len_q) && !c0TxAlmFull && (outst_q < MAX_OUT);
   assign accept   = (state_q == S_READ) && rsp_rd && !rsp_bad;

`ifdef GLM_LOAD_ERR_EN
   logic err_q, err_d;

   assign rsp_bad = rsp_rd && ((state_q == S_IDLE) || (outst_q == '0) ||
                               (cp2af_sRx_c0.hdr.mdata >= len_q));

   always_comb begin
      err_d = err_q;
      if ((state_q == S_IDLE) && op_start) err_d = 1'b0;
      if (rsp_bad)                         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign load_error = err_q;
`else
   assign rsp_bad    = 1'b0;
   assign load_error = 1'b0;
`endif

   always_comb begin
      // NOTE: every _d starts from its held value so no path through this block infers a latch.
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      chan_d  = chan_q;
      bbase_d = bbase_q;
      sent_d  = sent_q;
      rcvd_d  = rcvd_q;
      outst_d = outst_q;
      tx_d    = '0;
      we0_d   = 1'b0;
      we1_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (op_start) begin
               base_d  = sel_base + t_ccip_clAddr'(regs[3][30:0]);
               len_d   = regs[4][15:0];
               chan_d  = regs[5][3:0];
               bbase_d = regs[6][BRAM_AW-1:0];
               sent_d  = '0;
               rcvd_d  = '0;
               outst_d = '0;
               state_d = (regs[4][15:0] == 16'd0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (issue) begin
               tx_d.valid         = 1'b1;
               tx_d.hdr.address   = base_q + t_ccip_clAddr'(sent_q);
               tx_d.hdr.mdata     = sent_q;
               tx_d.hdr.req_type  = eREQ_RDLINE_I;
               tx_d.hdr.vc_sel    = eVC_VA;
               tx_d.hdr.cl_len    = eCL_LEN_1;
               sent_d             = sent_q + 16'd1;
            end
            // Channel codes other than 0/1 still count the line, they just discard it.
            if (accept) begin
               rcvd_d  = rcvd_q + 16'd1;
               we0_d   = (chan_q == 4'd0);
               we1_d   = (chan_q == 4'd1);
               waddr_d = bbase_q + cp2af_sRx_c0.hdr.mdata[BRAM_AW-1:0];
               wdata_d = cp2af_sRx_c0.data;
               if (rcvd_q + 16'd1 == len_q) state_d = S_DONE;
            end
            case ({issue, accept})
               2'b10:   outst_d = outst_q + OW'(1);
               2'b01:   outst_d = outst_q - OW'(1);
               default: outst_d = outst_q;
            endcase
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         chan_q  <= '0;
         bbase_q <= '0;
         sent_q  <= '0;
         rcvd_q  <= '0;
         outst_q <= '0;
         tx_q    <= '0;
         we0_q   <= 1'b0;
         we1_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         chan_q  <= chan_d;
         bbase_q <= bbase_d;
         sent_q  <= sent_d;
         rcvd_q  <= rcvd_d;
         outst_q <= outst_d;
         tx_q    <= tx_d;
         we0_q   <= we0_d;
         we1_q   <= we1_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

   // Both channels share one address/data register; only the write enables differ.
   assign af2cp_sTx_c0 = tx_q;
   assign mem0_we      = we0_q;
   assign mem1_we      = we1_q;
   assign mem0_waddr   = waddr_q;
   assign mem1_waddr   = waddr_q;
   assign mem0_wdata   = wdata_q;
   assign mem1_wdata   = wdata_q;
   assign op_done      = done_q;

   always_comb begin
      unused_ok = ^cp2af_sRx_c0;
      for (int i = 0; i < NUM_REGS; i++) unused_ok = unused_ok ^ (^regs[i]);
   end

endmodule

// File: tb/tb_glm_load_dram.sv
// Directed bench for glm_load_dram: address generation, out-of-order fill, backpressure,
// outstanding limit, zero length, reset abort, BRAM address wrap and discarded channels.
module tb_glm_load_dram;
   import glm_ccip_pkg::*;

   localparam int AW = 10;
   localparam int NR = 8;
`ifdef GLM_LOAD_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset, op_start_a, op_start_b, op_done_a, op_done_b, almfull;
   logic [31:0]    regs [NR];
   t_ccip_clAddr   in_addr, out_addr;
   t_if_ccip_c0_Rx rx;
   t_if_ccip_c0_Tx tx_a, tx_b;
   logic           a_we0, a_we1, b_we0, b_we1, a_err, b_err;
   logic [AW-1:0]  a_wa0, a_wa1, b_wa0, b_wa1;
   logic [511:0]   a_wd0, a_wd1, b_wd0, b_wd1;

   glm_load_dram #(.BRAM_AW(AW), .MAX_OUTSTANDING(64), .NUM_REGS(NR)) dut_a (
      .clk(clk), .reset(reset), .op_start(op_start_a), .op_done(op_done_a), .regs(regs),
      .in_addr(in_addr), .out_addr(out_addr), .c0TxAlmFull(almfull), .cp2af_sRx_c0(rx),
      .af2cp_sTx_c0(tx_a), .mem0_we(a_we0), .mem1_we(a_we1), .mem0_waddr(a_wa0),
      .mem1_waddr(a_wa1), .mem0_wdata(a_wd0), .mem1_wdata(a_wd1), .load_error(a_err));

   glm_load_dram #(.BRAM_AW(AW), .MAX_OUTSTANDING(2), .NUM_REGS(NR)) dut_b (
      .clk(clk), .reset(reset), .op_start(op_start_b), .op_done(op_done_b), .regs(regs),
      .in_addr(in_addr), .out_addr(out_addr), .c0TxAlmFull(almfull), .cp2af_sRx_c0(rx),
      .af2cp_sTx_c0(tx_b), .mem0_we(b_we0), .mem1_we(b_we1), .mem0_waddr(b_wa0),
      .mem1_waddr(b_wa1), .mem0_wdata(b_wd0), .mem1_wdata(b_wd1), .load_error(b_err));

   typedef struct {t_ccip_clAddr addr; logic [15:0] mdata; int cyc;} req_t;
   typedef struct {int ch; logic [AW-1:0] addr; logic [511:0] data; int cyc;} wr_t;

   req_t req_a[$], req_b[$];
   wr_t  wr_a[$];
   int   cyc_cnt = 0, done_a, done_a_cyc, done_b, wr_b_cnt;
   int   n_chk = 0, n_fail = 0;
   t_ccip_c0_ReqMemHdr hdr_last;

   always @(posedge clk) cyc_cnt++;

   always @(negedge clk) begin
      if (reset) begin
         if (tx_a.valid) begin
            req_a.push_back('{tx_a.hdr.address, tx_a.hdr.mdata, cyc_cnt});
            hdr_last = tx_a.hdr;
         end
         if (tx_b.valid) req_b.push_back('{tx_b.hdr.address, tx_b.hdr.mdata, cyc_cnt});
         if (a_we0) wr_a.push_back('{0, a_wa0, a_wd0, cyc_cnt});
         if (a_we1) wr_a.push_back('{1, a_wa1, a_wd1, cyc_cnt});
         if (b_we0 || b_we1) wr_b_cnt++;
         if (op_done_a) begin done_a++; done_a_cyc = cyc_cnt; end
         if (op_done_b) done_b++;
      end
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   function automatic logic [511:0] mk_data(input int t, input int m);
      logic [31:0] w;
      w = 32'hC0DE0000 ^ 32'(t * 256 + m);
      return {16{w}};
   endfunction

   task automatic clear_logs();
      req_a.delete(); req_b.delete(); wr_a.delete();
      done_a = 0; done_a_cyc = -1; done_b = 0; wr_b_cnt = 0;
   endtask

   task automatic start_op(input bit on_b, input bit sel, input int off, input int len,
                           input int ch, input int bb);
      regs[3] = {sel, 31'(off)};
      regs[4] = 32'(len);
      regs[5] = 32'(ch);
      regs[6] = 32'(bb);
      if (on_b) op_start_b = 1'b1; else op_start_a = 1'b1;
      tick();
      op_start_a = 1'b0;
      op_start_b = 1'b0;
   endtask

   task automatic send_rsp(input int m, input int t, input t_ccip_c0_rsp typ);
      rx = '0;
      rx.rspValid      = 1'b1;
      rx.hdr.resp_type = typ;
      rx.hdr.mdata     = 16'(m);
      rx.data          = mk_data(t, m);
      tick();
      rx = '0;
   endtask

   task automatic respond_a(input int order[$], input int t);
      foreach (order[i]) begin
         int w = 0;
         while (req_a.size() <= order[i] && w < 200) begin tick(); w++; end
         check("req_issued", 512'(req_a.size() > order[i]), 512'(1));
         send_rsp(order[i], t, eRSP_RDLINE);
      end
   endtask

   task automatic wait_done_a();
      int w = 0;
      while (done_a == 0 && w < 300) begin tick(); w++; end
      tick(3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ord[$];
      int c, bad, k, w;
      logic [AW-1:0] wrap_exp [6];

      reset = 1'b0; op_start_a = 1'b0; op_start_b = 1'b0; almfull = 1'b0; rx = '0;
      for (int i = 0; i < NR; i++) regs[i] = '0;
      in_addr = 42'h1000; out_addr = 42'h2000;
      clear_logs();
      tick(2);
      check("rst_valid", 512'(tx_a.valid), 512'(0));
      check("rst_done", 512'(op_done_a), 512'(0));
      check("rst_we", 512'({a_we0, a_we1}), 512'(0));
      check("rst_waddr", 512'(a_wa0), 512'(0));
      check("rst_err", 512'(a_err), 512'(0));
      reset = 1'b1;
      tick(2);

      // In-order fill from in_addr + 2 into channel 0 at base 8.
      clear_logs();
      start_op(0, 1'b1, 2, 4, 0, 8);
      ord = '{0, 1, 2, 3};
      respond_a(ord, 1);
      wait_done_a();
      check("t1_nreq", 512'(req_a.size()), 512'(4));
      for (int i = 0; i < 4; i++) begin
         check("t1_addr", 512'(req_a[i].addr), 512'(42'h1002 + 42'(i)));
         check("t1_mdata", 512'(req_a[i].mdata), 512'(i));
      end
      check("t1_rtype", 512'(hdr_last.req_type), 512'(eREQ_RDLINE_I));
      check("t1_vc", 512'(hdr_last.vc_sel), 512'(eVC_VA));
      check("t1_cllen", 512'(hdr_last.cl_len), 512'(eCL_LEN_1));
      check("t1_nwr", 512'(wr_a.size()), 512'(4));
      for (int i = 0; i < 4; i++) begin
         check("t1_ch", 512'(wr_a[i].ch), 512'(0));
         check("t1_waddr", 512'(wr_a[i].addr), 512'(8 + i));
         check("t1_wdata", wr_a[i].data, mk_data(1, i));
      end
      check("t1_ndone", 512'(done_a), 512'(1));
      check("t1_done_cyc", 512'(done_a_cyc), 512'(wr_a[3].cyc + 1));

      // Out-of-order responses from out_addr + 0x10 into channel 1 at base 100.
      clear_logs();
      start_op(0, 1'b0, 'h10, 4, 1, 100);
      ord = '{3, 1, 0, 2};
      respond_a(ord, 2);
      wait_done_a();
      for (int i = 0; i < 4; i++)
         check("t2_addr", 512'(req_a[i].addr), 512'(42'h2010 + 42'(i)));
      check("t2_nwr", 512'(wr_a.size()), 512'(4));
      foreach (ord[i]) begin
         check("t2_ch", 512'(wr_a[i].ch), 512'(1));
         check("t2_waddr", 512'(wr_a[i].addr), 512'(100 + ord[i]));
         check("t2_wdata", wr_a[i].data, mk_data(2, ord[i]));
      end
      check("t2_ndone", 512'(done_a), 512'(1));

      // c0TxAlmFull held for 5 cycles mid-burst.
      clear_logs();
      start_op(0, 1'b1, 'h40, 8, 0, 0);
      w = 0;
      while (req_a.size() < 3 && w < 50) begin tick(); w++; end
      c = cyc_cnt;
      almfull = 1'b1;
      tick(5);
      almfull = 1'b0;
      ord = '{0, 1, 2, 3, 4, 5, 6, 7};
      respond_a(ord, 3);
      wait_done_a();
      bad = 0; k = 0;
      foreach (req_a[i]) begin
         if (req_a[i].cyc > c && req_a[i].cyc <= c + 5) bad++;
         if (req_a[i].cyc <= c) k++;
      end
      check("t3_blocked", 512'(bad), 512'(0));
      check("t3_resume_cyc", 512'(req_a[k].cyc), 512'(c + 6));
      check("t3_nreq", 512'(req_a.size()), 512'(8));
      for (int i = 0; i < 8; i++)
         check("t3_addr", 512'(req_a[i].addr), 512'(42'h1040 + 42'(i)));
      check("t3_ndone", 512'(done_a), 512'(1));

      // Outstanding limit of 2 on the second instance, responses fed one at a time.
      clear_logs();
      start_op(1, 1'b1, 0, 6, 0, 0);
      tick(8);
      check("t4_stall", 512'(req_b.size()), 512'(2));
      for (int m = 0; m < 6; m++) begin
         send_rsp(m, 4, eRSP_RDLINE);
         tick(3);
         check("t4_resume", 512'(req_b.size()), 512'((m + 3 > 6) ? 6 : m + 3));
      end
      w = 0;
      while (done_b == 0 && w < 50) begin tick(); w++; end
      tick(2);
      check("t4_ndone", 512'(done_b), 512'(1));
      check("t4_nwr", 512'(wr_b_cnt), 512'(6));

      // Zero length: no requests, op_done two cycles after op_start.
      clear_logs();
      c = cyc_cnt;
      start_op(0, 1'b1, 0, 0, 0, 0);
      tick(5);
      check("t5_nreq", 512'(req_a.size()), 512'(0));
      check("t5_ndone", 512'(done_a), 512'(1));
      check("t5_done_cyc", 512'(done_a_cyc), 512'(c + 2));

      // Reset mid-burst, then a stray response.
      clear_logs();
      start_op(0, 1'b1, 0, 8, 0, 0);
      w = 0;
      while (req_a.size() < 3 && w < 50) begin tick(); w++; end
      reset = 1'b0;
      #1;
      check("t6_rst_valid", 512'(tx_a.valid), 512'(0));
      check("t6_rst_done", 512'(op_done_a), 512'(0));
      tick(2);
      reset = 1'b1;
      clear_logs();
      send_rsp(1, 6, eRSP_RDLINE);
      tick(4);
      check("t6_nwr", 512'(wr_a.size()), 512'(0));
      check("t6_nreq", 512'(req_a.size()), 512'(0));
      check("t6_err", 512'(a_err), 512'(ERR_EN));

      // BRAM base 1020 wraps; a non-RDLINE response is ignored.
      clear_logs();
      start_op(0, 1'b1, 0, 6, 0, 1020);
      send_rsp(0, 9, eRSP_UMSG);
      ord = '{0, 1, 2, 3, 4, 5};
      respond_a(ord, 7);
      wait_done_a();
      wrap_exp = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1};
      check("t7_nwr", 512'(wr_a.size()), 512'(6));
      for (int i = 0; i < 6; i++) begin
         check("t7_waddr", 512'(wr_a[i].addr), 512'(wrap_exp[i]));
         check("t7_wdata", wr_a[i].data, mk_data(7, i));
      end
      check("t7_ndone", 512'(done_a), 512'(1));
      check("t7_err", 512'(a_err), 512'(0));

      // Channel 5 discards the lines but still completes.
      clear_logs();
      start_op(0, 1'b1, 0, 2, 5, 0);
      ord = '{0, 1};
      respond_a(ord, 8);
      wait_done_a();
      check("t8_nwr", 512'(wr_a.size()), 512'(0));
      check("t8_ndone", 512'(done_a), 512'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
